sy_sim_ctrl: RTL

Simulation control and console slave attached to the memory bus of `sy_soc_sim`; it consumes the core's stores to TOHOST and PUTCHAR and turns them into end-of-test status and a paced console character stream.
- It sits directly downstream of the SoC and upstream of the testbench, which watches `done_o` to call `$finish` and drains `char_o` to the log.
- It contains a free-running cycle counter, a 16-entry console FIFO with paced drain, sticky pass/fail latching and a timeout watchdog.

---
 rtl/sy_sim_pkg.sv | 29 ++
 rtl/sy_sim_ctrl_if.sv | 21 ++
 rtl/sy_sim_fifo.sv | 51 +++++
 rtl/sy_sim_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/sy_sim_pkg.sv
// Shared definitions for the simulation control / console slave:
// register offsets, STATUS bit layout and the STATUS word struct.
package sy_sim_pkg;

  localparam logic [1:0] SIM_TOHOST  = 2'd0;
  localparam logic [1:0] SIM_PUTCHAR = 2'd1;
  localparam logic [1:0] SIM_STATUS  = 2'd2;
  localparam logic [1:0] SIM_CYCLE   = 2'd3;

  localparam int STS_DONE_BIT    = 0;
  localparam int STS_PASS_BIT    = 1;
  localparam int STS_TIMEOUT_BIT = 2;
  localparam int STS_COUNT_LSB   = 8;
  localparam int STS_COUNT_W     = 5;

  typedef struct packed {
    logic [50:0] rsvd_hi;
    logic [4:0]  count;
    logic [4:0]  rsvd_lo;
    logic        timeout;
    logic        pass;
    logic        done;
  } sim_status_t;

  function automatic logic [1:0] sim_sel(input logic [11:0] addr);
    return addr[4:3];
  endfunction

endpackage

// File: rtl/sy_sim_ctrl_if.sv
// Memory-bus port between the SoC (master) and the sim control slave.
interface sy_sim_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [11:0] addr_i;
  logic [63:0] wdata_i;
  logic [7:0]  be_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [63:0] rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/sy_sim_fifo.sv
// Synchronous FIFO, power-of-two depth; pushes when full and pops when
// empty are dropped, a simultaneous push+pop leaves the count unchanged.
module sy_sim_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sy_sim_ctrl.sv
// Simulation control slave: TOHOST end-of-test latch, paced PUTCHAR console
// FIFO, STATUS/CYCLE readback and a cycle watchdog; 1-cycle read latency.
module sy_sim_ctrl
  import sy_sim_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter int          DRAIN_DIV  = 4,
  parameter logic [63:0] TIMEOUT    = 64'd10_000_000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  sy_sim_ctrl_if.slave       bus,
  output logic               char_valid_o,
  output logic [7:0]         char_o,
  input  logic               char_ready_i,
  output logic               done_o,
  output logic               pass_o,
  output logic               timeout_o,
  output logic [62:0]        exit_code_o
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PACE_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  logic [1:0]        sel;
  logic              accept;
  logic              push;
  logic              pop;
  logic              tohost_wr;
  logic              wd_hit;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW:0]       fifo_count;
  logic [PACE_W-1:0] pace;
  logic [63:0]       cycle;
  logic [63:0]       rd_val;
  sim_status_t       sts;
  logic              unused_bits;

  assign sel = sim_sel(bus.addr_i);

  // Full comes from the registered count, so a pop in this cycle cannot grant a blocked push.
  assign bus.gnt_o = bus.req_i && !(bus.we_i && sel == SIM_PUTCHAR && fifo_full);
  assign accept    = bus.req_i && bus.gnt_o;
  assign push      = accept && bus.we_i && sel == SIM_PUTCHAR && bus.be_i[0];
  assign tohost_wr = accept && bus.we_i && sel == SIM_TOHOST && bus.be_i[0]
                     && bus.wdata_i[0] && !done_o;
  assign wd_hit    = (TIMEOUT != 64'd0) && (cycle == TIMEOUT - 64'd1) && !done_o;

  assign char_valid_o = !fifo_empty && (pace == '0);
  assign pop          = char_valid_o && char_ready_i;

  assign unused_bits = ^{bus.addr_i[11:5], bus.addr_i[2:0], bus.be_i[7:1]};

  sy_sim_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .push     (push),
    .push_dat (bus.wdata_i[7:0]),
    .pop      (pop),
    .pop_dat  (char_o),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    sts         = '0;
    sts.count   = 5'(fifo_count);
    sts.timeout = timeout_o;
    sts.pass    = pass_o;
    sts.done    = done_o;
    rd_val      = '0;
    case (sel)
      SIM_STATUS: rd_val = sts;
      SIM_CYCLE:  rd_val = cycle;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.rvalid_o <= 1'b0;
      bus.rdata_o  <= '0;
      cycle        <= '0;
      pace         <= '0;
      done_o       <= 1'b0;
      pass_o       <= 1'b0;
      timeout_o    <= 1'b0;
      exit_code_o  <= '0;
    end else begin
      bus.rvalid_o <= accept;
      bus.rdata_o  <= (accept && !bus.we_i) ? rd_val : 64'd0;
      cycle        <= cycle + 64'd1;

      if (pop)              pace <= PACE_W'(DRAIN_DIV - 1);
      else if (pace != '0)  pace <= pace - 1'b1;

      // An accepted TOHOST write wins over a watchdog expiry in the same cycle.
      if (tohost_wr) begin
        done_o      <= 1'b1;
        pass_o      <= (bus.wdata_i[63:1] == 63'd0);
        exit_code_o <= bus.wdata_i[63:1];
      end else if (wd_hit) begin
        done_o      <= 1'b1;
        pass_o      <= 1'b0;
        timeout_o   <= 1'b1;
        exit_code_o <= '1;
      end
    end
  end

endmodule
